// File: rtl/vga_pkg.sv
// Shared types, colour constants and default 640x480@60 timing for the VGA timing generator.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BLACK   = rgb_t'(24'h000000);
    localparam rgb_t WHITE   = rgb_t'(24'hFFFFFF);
    localparam rgb_t PINK    = rgb_t'(24'hFFC0CB);
    localparam rgb_t YELLOW  = rgb_t'(24'hFFFF00);
    localparam rgb_t CYAN    = rgb_t'(24'h00FFFF);
    localparam rgb_t GREEN   = rgb_t'(24'h00FF00);
    localparam rgb_t MAGENTA = rgb_t'(24'hFF00FF);
    localparam rgb_t RED     = rgb_t'(24'hFF0000);
    localparam rgb_t BLUE    = rgb_t'(24'h0000FF);

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Colour of test-pattern bar idx, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_if.sv
// Renderer/DAC-side bundle of the VGA timing generator: pixel strobe, colour in, coordinates and video out.
interface vga_if #(parameter int CW = 10) ();

    logic          pix_en;
    logic [23:0]   rgb_in;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          coord_valid;
    logic          frame_start;
    logic          line_start;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;

    modport master (
        input  pix_en, rgb_in,
        output pixel_x, pixel_y, coord_valid, frame_start, line_start,
               hsync, vsync, video_on, red, green, blue
    );

    modport slave (
        output pix_en, rgb_in,
        input  pixel_x, pixel_y, coord_valid, frame_start, line_start,
               hsync, vsync, video_on, red, green, blue
    );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; clears to zero on reset.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per enable strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else if (en) begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with renderer re-alignment and colour output stage.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with eight vertical colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PIPE_DELAY = 2,
    parameter int CW         = 10
) (
    input  logic  VGA_CLK_IN,
    input  logic  reset,
    output logic  VGA_CLK_OUT,
    vga_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SB_C   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SB_C   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);

    if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_pipe_delay
        $error("vga_timing_gen: PIPE_DELAY must be in 1..8");
    end
    if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    logic [CW-1:0] pixel_x_r;
    logic [CW-1:0] pixel_y_r;
    logic          coord_valid_r;
    logic          frame_start_r;
    logic          line_start_r;
    logic          video_on_r;
    logic          hsync_r;
    logic          vsync_r;
    rgb_t          colour_r;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic [2:0]    flags_s;      // {active, raw hsync, raw vsync}, active-high
    logic [2:0]    flags_dly_s;
    rgb_t          src_s;

    // Decode the current counter position.
    always_comb begin
        h_wrap_s = (h_cnt_r == H_LAST_C);
        v_wrap_s = (v_cnt_r == V_LAST_C);
        flags_s  = {(h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C),
                    (h_cnt_r >= H_SB_C) && (h_cnt_r < H_SE_C),
                    (v_cnt_r >= V_SB_C) && (v_cnt_r < V_SE_C)};
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge VGA_CLK_IN) begin
        if (reset) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (vga.pix_en) begin
            if (h_wrap_s) begin
                h_cnt_r <= '0;
                v_cnt_r <= v_wrap_s ? '0 : v_cnt_r + CW'(1);
            end else begin
                h_cnt_r <= h_cnt_r + CW'(1);
            end
        end
    end

    // Stage 0: undelayed coordinates and strobe-qualified start pulses.
    always_ff @(posedge VGA_CLK_IN) begin
        if (reset) begin
            pixel_x_r     <= '0;
            pixel_y_r     <= '0;
            coord_valid_r <= 1'b0;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
        end else begin
            frame_start_r <= vga.pix_en && (h_cnt_r == '0) && (v_cnt_r == '0);
            line_start_r  <= vga.pix_en && (h_cnt_r == '0);
            if (vga.pix_en) begin
                pixel_x_r     <= h_cnt_r;
                pixel_y_r     <= v_cnt_r;
                coord_valid_r <= flags_s[2];
            end
        end
    end

    // The delay line runs one stage ahead of stage 0; the output register below completes PIPE_DELAY.
    vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY)) u_flag_dly (
        .clk   (VGA_CLK_IN),
        .reset (reset),
        .en    (vga.pix_en),
        .d     (flags_s),
        .q     (flags_dly_s)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [CW-1:0] x_dly_s;
    logic [2:0]    bar_s;

    vga_delay_line #(.WIDTH(CW), .DEPTH(PIPE_DELAY)) u_x_dly (
        .clk   (VGA_CLK_IN),
        .reset (reset),
        .en    (vga.pix_en),
        .d     (h_cnt_r),
        .q     (x_dly_s)
    );

    // Bar index by threshold count, avoiding a divider.
    always_comb begin
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_dly_s >= CW'(k * BAR_W)) begin
                bar_s = bar_s + 3'd1;
            end else begin
                bar_s = bar_s;
            end
        end
        src_s = bar_colour(bar_s);
    end
`else
    // Renderer colour passes straight to the output register.
    always_comb begin
        src_s = rgb_t'(vga.rgb_in);
    end
`endif

    // Output stage: polarity applied here so the pipeline holds active-high flags only.
    always_ff @(posedge VGA_CLK_IN) begin
        if (reset) begin
            video_on_r <= 1'b0;
            hsync_r    <= ~HSYNC_POL;
            vsync_r    <= ~VSYNC_POL;
            colour_r   <= BLACK;
        end else if (vga.pix_en) begin
            video_on_r <= flags_dly_s[2];
            hsync_r    <= flags_dly_s[1] ? HSYNC_POL : ~HSYNC_POL;
            vsync_r    <= flags_dly_s[0] ? VSYNC_POL : ~VSYNC_POL;
            colour_r   <= flags_dly_s[2] ? src_s : BLACK;
        end
    end

    assign VGA_CLK_OUT     = VGA_CLK_IN;
    assign vga.pixel_x     = pixel_x_r;
    assign vga.pixel_y     = pixel_y_r;
    assign vga.coord_valid = coord_valid_r;
    assign vga.frame_start = frame_start_r;
    assign vga.line_start  = line_start_r;
    assign vga.video_on    = video_on_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.red         = colour_r.r;
    assign vga.green       = colour_r.g;
    assign vga.blue        = colour_r.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 24x11 raster with PIPE_DELAY=3 and mixed sync polarity.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int PD       = 3;
    localparam int CW       = 6;
    localparam bit HPOL     = 1'b1;
    localparam bit VPOL     = 1'b0;

    typedef struct packed {
        logic        vid;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clk_out;

    vga_if #(.CW(CW)) vga ();

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .PIPE_DELAY(PD), .CW(CW)
    ) dut (
        .VGA_CLK_IN  (clk),
        .reset       (rst),
        .VGA_CLK_OUT (clk_out),
        .vga         (vga)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t            sb[$];
    exp_t            cur;
    logic [2*CW-1:0] hist[$];
    int m_h, m_v;
    int exp_x, exp_y;
    logic exp_cv, exp_fs, exp_ls;
    int cyc, last_fs, last_ls, exp_fp, exp_lp;

`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic exp_t inactive();
        exp_t e;
        e.vid = 1'b0;
        e.hs  = ~HPOL;
        e.vs  = ~VPOL;
        e.rgb = 24'h000000;
        return e;
    endfunction

    function automatic exp_t mk(input int x, input int y);
        exp_t e;
        logic hs_act, vs_act;
        e.vid  = (x < H_ACTIVE) && (y < V_ACTIVE);
        hs_act = (x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC);
        vs_act = (y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC);
        e.hs   = hs_act ? HPOL : ~HPOL;
        e.vs   = vs_act ? VPOL : ~VPOL;
`ifdef VGA_TEST_PATTERN_EN
        e.rgb  = e.vid ? bar_tab[x / (H_ACTIVE / 8)] : 24'h000000;
`else
        e.rgb  = e.vid ? {8'(x), 8'(y), 8'hA5} : 24'h000000;
`endif
        return e;
    endfunction

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < PD; i++) sb.push_back(inactive());
        cur = inactive();
        hist.delete();
        m_h = 0; m_v = 0;
        exp_x = 0; exp_y = 0;
        exp_cv = 1'b0; exp_fs = 1'b0; exp_ls = 1'b0;
    endtask

    // One clock: drive inputs, advance the model on the edge, compare every output.
    task automatic step(input logic en, input logic r);
        logic [2*CW-1:0] c;
        vga.pix_en = en;
        rst = r;
        if (en && hist.size() >= PD) begin
            c = hist[hist.size() - PD];
            vga.rgb_in = {8'(c[2*CW-1:CW]), 8'(c[CW-1:0]), 8'hA5};
        end else begin
            vga.rgb_in = 24'($urandom);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            exp_fs = en && (m_h == 0) && (m_v == 0);
            exp_ls = en && (m_h == 0);
            if (en) begin
                exp_x  = m_h;
                exp_y  = m_v;
                exp_cv = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
                sb.push_back(mk(m_h, m_v));
                cur = sb.pop_front();
                hist.push_back({CW'(m_h), CW'(m_v)});
                while (hist.size() > PD + 2) void'(hist.pop_front());
                if (m_h == H_TOTAL - 1) begin
                    m_h = 0;
                    m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
        end
        check("pixel_x",     32'(vga.pixel_x),     32'(exp_x));
        check("pixel_y",     32'(vga.pixel_y),     32'(exp_y));
        check("coord_valid", 32'(vga.coord_valid), 32'(exp_cv));
        check("frame_start", 32'(vga.frame_start), 32'(exp_fs));
        check("line_start",  32'(vga.line_start),  32'(exp_ls));
        check("video_on",    32'(vga.video_on),    32'(cur.vid));
        check("hsync",       32'(vga.hsync),       32'(cur.hs));
        check("vsync",       32'(vga.vsync),       32'(cur.vs));
        check("rgb",         32'({vga.red, vga.green, vga.blue}), 32'(cur.rgb));
        check("clk_out",     32'(clk_out),         32'(clk));
        if (vga.frame_start) begin
            if (last_fs >= 0 && exp_fp > 0) check("frame_period", 32'(cyc - last_fs), 32'(exp_fp));
            last_fs = cyc;
        end
        if (vga.line_start) begin
            if (last_ls >= 0 && exp_lp > 0) check("line_period", 32'(cyc - last_ls), 32'(exp_lp));
            last_ls = cyc;
        end
    endtask

    task automatic set_periods(input int fp, input int lp);
        exp_fp  = fp;
        exp_lp  = lp;
        last_fs = -1;
        last_ls = -1;
    endtask

    initial begin
        rst        = 1'b1;
        vga.pix_en = 1'b1;
        vga.rgb_in = 24'h000000;
        cyc        = 0;
        model_reset();
        set_periods(0, 0);
        repeat (3) step(1'b1, 1'b1);

        // Continuous strobe: two full frames.
        set_periods(FRAME, H_TOTAL);
        repeat (2 * FRAME + 5) step(1'b1, 1'b0);

        // Strobe every other clock: periods double, outputs hold on idle clocks.
        set_periods(2 * FRAME, 2 * H_TOTAL);
        for (int i = 0; i < 4 * FRAME + 4; i++) step(logic'(i % 2 == 0), 1'b0);

        // Irregular strobe pattern.
        set_periods(0, 0);
        repeat (300) step(logic'($urandom_range(0, 1)), 1'b0);

        // Reset inside the sync windows with pix_en low, then one more frame.
        for (int i = 0; i < 2 * FRAME && !(m_h == 19 && m_v == 7); i++) step(1'b1, 1'b0);
        check("reset_point", 32'(m_h * 100 + m_v), 32'(1907));
        step(1'b0, 1'b1);
        set_periods(FRAME, H_TOTAL);
        repeat (FRAME + PD + 5) step(1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator and pixel output stage; successor of the fixed 640x480 sync block.
- Produces pixel coordinates for the text/graphics renderer, then re-aligns hsync/vsync/blanking with the renderer's colour after a configurable pipeline delay.
- Sits between the 25 MHz pixel-clock domain and the board VGA DAC.
- Supports pixel-enable strobing, so it can run from a faster clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- PIPE_DELAY, 2, renderer latency in pixel strobes (1..8)
- CW, 10, coordinate counter width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL

Ports:
- VGA_CLK_IN  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; tie to 1 for a 25 MHz clock
- rgb_in  in  24  {R,G,B} from the renderer, valid PIPE_DELAY strobes after the matching coordinate
- pixel_x  out  CW  current column (undelayed)
- pixel_y  out  CW  current line (undelayed)
- coord_valid  out  1  pixel_x/pixel_y lie in the active area
- frame_start  out  1  one-clock pulse at h=0, v=0
- line_start  out  1  one-clock pulse at h=0 of every line
- hsync  out  1  delayed, polarity per HSYNC_POL
- vsync  out  1  delayed, polarity per VSYNC_POL
- video_on  out  1  delayed active-area flag
- red  out  8  rgb_in[23:16] when video_on, else 0
- green  out  8  rgb_in[15:8] when video_on, else 0
- blue  out  8  rgb_in[7:0] when video_on, else 0
- VGA_CLK_OUT  out  1  direct copy of VGA_CLK_IN

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line/frame order is active, front porch, sync, back porch.
- h_cnt advances only on pix_en. It wraps H_TOTAL-1 -> 0.
- v_cnt increments when h_cnt wraps. It wraps V_TOTAL-1 -> 0; no extra line (exactly V_TOTAL lines per frame).
- pix_en low: all counters, pipeline stages and outputs hold their values. frame_start and line_start stay 0.
- Stage 0 (registered from the counters):
  - pixel_x = h_cnt, pixel_y = v_cnt.
  - coord_valid = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - raw hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - raw vsync active for the corresponding v_cnt window, for whole lines.
- Alignment: {coord_valid, raw hsync, raw vsync} pass through a PIPE_DELAY-deep shift register clocked by pix_en.
  - The outputs video_on, hsync and vsync are the last stage.
- Colour: red/green/blue are registered in the same strobe as the last stage, from rgb_in gated by the delayed video_on.
  - rgb_in is never forwarded while blanking.
- Latency: coordinate (x,y) presented on strobe n; its colour appears on red/green/blue on strobe n+PIPE_DELAY, together with its own hsync/vsync/video_on.
- frame_start and line_start are undelayed single-clock pulses coincident with the stage-0 update, qualified by pix_en.
- Reset values: counters and pixel_x/pixel_y 0; coord_valid 0; video_on 0; colours 0; frame_start and line_start 0.
  - hsync and vsync go to their inactive level (~HSYNC_POL, ~VSYNC_POL), never to 0 irrespective of polarity.
  - All pipeline stages hold inactive values.
- First strobe after reset: stage 0 reflects h=0, v=0 and frame_start pulses.
- Reset mid-frame: takes effect on the next edge regardless of pix_en. The frame restarts at (0,0) with no partial sync pulse retained.
- Elaboration-time check: $error if PIPE_DELAY is outside 1..8 or CW is too narrow.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined: rgb_in is ignored. The colour stage uses 8 vertical bars, each H_ACTIVE/8 wide: white, yellow, cyan, green, magenta, red, blue, black.
  - Bars are selected from the delayed x coordinate, so timing and latency are unchanged.
- Undefined: rgb_in is used; no pattern logic is synthesised.

Decomposition:
- Package vga_pkg:
  - rgb_t (24-bit packed struct r,g,b).
  - Colour constants BLACK, PINK, WHITE and the bar colours.
  - Default 640x480@60 timing localparams.
- Sub-module vga_delay_line (param WIDTH, DEPTH; ports clk, reset, en, d, q).
  - Used once for the sync/flag bundle and, under VGA_TEST_PATTERN_EN, once for pixel_x.

Test Plan:
- Defaults, pix_en=1, run 2 frames -> line period 800 clocks; hsync low for exactly 96 clocks starting at h=656; vsync low for lines 490-491; frame period 420000 clocks; frame_start every 420000.
- PIPE_DELAY=3, rgb_in = {pixel_x[7:0], pixel_y[7:0], 8'hA5} fed back through a 3-deep model -> red/green/blue equal the expected coordinate colour; colour 0 whenever video_on=0; hsync edge 3 strobes after the raw position.
- pix_en toggled 1,0,1,0 -> counters advance every other clock; the pulse period doubles to 1600 clocks; outputs are stable on the low cycles.
- reset asserted at h=300, v=200 for 1 clock -> next clock pixel_x=0, pixel_y=0; hsync/vsync inactive; video_on=0; frame_start pulses on the first strobe after release.
- HSYNC_POL=1, VSYNC_POL=1 -> reset level of both syncs 0; active level 1; pulse widths unchanged.
- VGA_TEST_PATTERN_EN defined, defaults -> x=0 white (FFFFFF); x=80 yellow (FFFF00); x=639 black; rgb_in ignored.
